// File: rtl/knots_ascii_encoder.sv
// knots_ascii_encoder
// Converts an mph x100 speed into knots x100 with rounding, then streams it
// out as the six ASCII characters DDD.DD over a valid/ready byte interface.
// The arithmetic is deliberately sequential: one multiply, a 26-step
// restoring divide by 1000 and a 16-step double-dabble.

module knots_ascii_encoder #(
   parameter int K_NUM = 869
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] mph_x100_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic [15:0] knots_x100_out,
   output logic        done
);

   localparam logic [25:0] K_MULT   = 26'(K_NUM);
   localparam logic [25:0] ROUNDING = 26'd500;
   localparam logic [11:0] DIVISOR  = 12'd1000;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      BCD,
      SEND
   } stateT;

   stateT       r_state;
   stateT       w_nextState;

   logic [15:0] r_mph;
   logic [25:0] r_prod;
   logic [10:0] r_rem;
   logic [15:0] r_quot;
   logic [4:0]  r_cnt;
   logic [15:0] r_bin;
   logic [19:0] r_bcd;
   logic [2:0]  r_idx;
   logic        r_outValid;
   logic [7:0]  r_outData;
   logic        r_outLast;
   logic [15:0] r_knots;
   logic        r_done;

   logic [25:0] w_prod;
   logic [11:0] w_trial;
   logic        w_ge;
   logic [10:0] w_remNext;
   logic [15:0] w_quotNext;
   logic [19:0] w_adj;
   logic [7:0]  w_byteCur;
   logic [7:0]  w_byteNext;
   logic        w_lastHandshake;

   // ASCII character for a given output position: three integer digits, the
   // dot, then two fractional digits. Digits are 0..9 so +0x30 is just a
   // high nibble of 3.
   function automatic logic [7:0] byteOf(input logic [2:0] idx, input logic [19:0] bcd);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = {4'h3, bcd[19:16]};
         3'd1:    b = {4'h3, bcd[15:12]};
         3'd2:    b = {4'h3, bcd[11:8]};
         3'd3:    b = 8'h2E;
         3'd4:    b = {4'h3, bcd[7:4]};
         3'd5:    b = {4'h3, bcd[3:0]};
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Datapath helpers: rounded product, one restoring-divide step, one
   // double-dabble digit adjust, and the byte lookups for the sender.
   always_comb begin
      w_prod          = {10'd0, r_mph} * K_MULT + ROUNDING;
      w_trial         = {r_rem, r_prod[25]};
      w_ge            = (w_trial >= DIVISOR);
      w_remNext       = w_ge ? 11'(w_trial - DIVISOR) : w_trial[10:0];
      w_quotNext      = 16'({r_quot, w_ge});
      w_adj           = r_bcd;
      for (int d = 0; d < 5; d++) begin
         if (r_bcd[d*4 +: 4] >= 4'd5) begin
            w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
         end
      end
      w_byteCur       = byteOf(r_idx, r_bcd);
      w_byteNext      = byteOf(r_idx + 3'd1, r_bcd);
      w_lastHandshake = r_outValid && out_ready && (r_idx == 3'd5);
   end

   // State register; reset abandons whatever conversion is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state sequencing through multiply, divide, BCD and send phases.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)              w_nextState = MUL;
         MUL:                                w_nextState = DIV;
         DIV:     if (r_cnt == 5'd25)        w_nextState = BCD;
         BCD:     if (r_cnt == 5'd15)        w_nextState = SEND;
         SEND:    if (w_lastHandshake)       w_nextState = IDLE;
         default:                            w_nextState = IDLE;
      endcase
   end

   // Arithmetic pipeline registers and the registered byte-stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mph      <= '0;
         r_prod     <= '0;
         r_rem      <= '0;
         r_quot     <= '0;
         r_cnt      <= '0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_idx      <= '0;
         r_outValid <= 1'b0;
         r_outData  <= 8'h00;
         r_outLast  <= 1'b0;
         r_knots    <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mph <= mph_x100_in;
               end
            end
            MUL: begin
               r_prod <= w_prod;
               r_rem  <= '0;
               r_quot <= '0;
               r_cnt  <= '0;
            end
            DIV: begin
               r_prod <= {r_prod[24:0], 1'b0};
               r_rem  <= w_remNext;
               r_quot <= w_quotNext;
               if (r_cnt == 5'd25) begin
                  r_knots <= w_quotNext;
                  r_bin   <= w_quotNext;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            BCD: begin
               r_bcd <= 20'({w_adj, r_bin[15]});
               r_bin <= {r_bin[14:0], 1'b0};
               if (r_cnt == 5'd15) begin
                  r_cnt <= '0;
                  r_idx <= '0;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            SEND: begin
               if (!r_outValid) begin
                  r_outValid <= 1'b1;
                  r_outData  <= w_byteCur;
                  r_outLast  <= (r_idx == 3'd5);
               end else if (out_ready) begin
                  if (r_idx == 3'd5) begin
                     r_outValid <= 1'b0;
                     r_outLast  <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_idx     <= r_idx + 3'd1;
                     r_outData <= w_byteNext;
                     r_outLast <= (r_idx == 3'd4);
                  end
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign in_ready       = (r_state == IDLE) && !rst;
   assign out_valid      = r_outValid;
   assign out_data       = r_outData;
   assign out_last       = r_outLast;
   assign knots_x100_out = r_knots;
   assign done           = r_done;

endmodule

// File: tb/tb_knots_ascii_encoder.sv
// Directed bench for knots_ascii_encoder: hand-computed conversions,
// latency, back-pressure, busy-input rejection and mid-transfer reset.

module tb_knots_ascii_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] mph_x100_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [15:0] knots_x100_out;
   logic        done;

   int testCount = 0;
   int failCount = 0;

   knots_ascii_encoder #(.K_NUM(869)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .mph_x100_in    (mph_x100_in),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .knots_x100_out (knots_x100_out),
      .done           (done)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, observed running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Present one input sample and return at the negedge following its accept edge
   task automatic applyStimulus(input logic [15:0] mph, input bit holdValid, output bit ok);
      int budget;
      budget      = 0;
      in_valid    = 1'b1;
      mph_x100_in = mph;
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         checkOutput("acceptTimeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         ok       = 1'b0;
         return;
      end
      ok = 1'b1;
      @(negedge clk);
      if (!holdValid) in_valid = 1'b0;
   endtask

   // Follow one conversion from the negedge after its accept edge through done
   task automatic runFrame(input string tag, input logic [47:0] expStr, input logic [15:0] expKnots,
                           input int readyPct, input bit busyPulse, input bit checkLat);
      int          edges;
      int          busyErr;
      int          stallErr;
      int          earlyDone;
      int          nBytes;
      logic [47:0] got;
      logic [5:0]  lastSeen;
      bit          prevStall;
      bit          rdy;
      logic [7:0]  prevData;
      edges = 0; busyErr = 0; stallErr = 0; earlyDone = 0; nBytes = 0;
      got = '0; lastSeen = '0; prevStall = 1'b0; prevData = 8'h00;

      while (!out_valid && edges < 100) begin
         if (busyPulse) begin
            in_valid    = 1'($urandom_range(1));
            mph_x100_in = 16'd4321;
         end
         if (in_ready) busyErr++;
         if (done) earlyDone++;
         @(negedge clk);
         edges++;
      end
      if (busyPulse) in_valid = 1'b0;
      if (!out_valid) begin
         checkOutput({tag, "_firstByteTimeout"}, 64'd0, 64'd1);
         return;
      end
      if (checkLat) checkOutput({tag, "_latency"}, 64'(edges), 64'd44);
      checkOutput({tag, "_knots"}, 64'(knots_x100_out), 64'(expKnots));

      edges = 0;
      while (nBytes < 6 && edges < 400) begin
         if (done) earlyDone++;
         if (busyPulse && in_ready) busyErr++;
         if (prevStall && (!out_valid || out_data !== prevData)) stallErr++;
         if (out_valid) begin
            rdy       = ($urandom_range(99) < readyPct);
            out_ready = rdy;
            if (rdy) begin
               got      = {got[39:0], out_data};
               lastSeen = {lastSeen[4:0], out_last};
               nBytes++;
            end
            prevStall = !rdy;
            prevData  = out_data;
         end else begin
            out_ready = 1'b0;
            prevStall = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      out_ready = 1'b0;

      checkOutput({tag, "_string"},    64'(got),       64'(expStr));
      checkOutput({tag, "_lastFlag"},  64'(lastSeen),  64'b000001);
      checkOutput({tag, "_stall"},     64'(stallErr),  64'd0);
      checkOutput({tag, "_busyReady"}, 64'(busyErr),   64'd0);
      checkOutput({tag, "_earlyDone"}, 64'(earlyDone), 64'd0);
      checkOutput({tag, "_done"},      64'(done),      64'd1);
      checkOutput({tag, "_readyAtDone"}, 64'(in_ready), 64'd1);
      checkOutput({tag, "_validAfter"},  64'(out_valid), 64'd0);
      @(negedge clk);
      checkOutput({tag, "_donePulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      bit ok;
      int budget;
      int doneSeen;

      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      mph_x100_in = 16'd0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_inReady",  64'(in_ready),       64'd0);
      checkOutput("rst_outValid", 64'(out_valid),      64'd0);
      checkOutput("rst_outData",  64'(out_data),       64'd0);
      checkOutput("rst_outLast",  64'(out_last),       64'd0);
      checkOutput("rst_done",     64'(done),           64'd0);
      checkOutput("rst_knots",    64'(knots_x100_out), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("rst_inReadyAfter", 64'(in_ready), 64'd1);
      @(negedge clk);

      // Zero speed, then rounding-boundary values, then full scale
      applyStimulus(16'd0, 1'b0, ok);
      if (ok) runFrame("mph0", "000.00", 16'd0, 100, 1'b0, 1'b1);
      applyStimulus(16'd1150, 1'b0, ok);
      if (ok) runFrame("mph1150", "009.99", 16'd999, 100, 1'b0, 1'b1);
      applyStimulus(16'd1, 1'b0, ok);
      if (ok) runFrame("mph1", "000.01", 16'd1, 100, 1'b0, 1'b1);
      applyStimulus(16'd65535, 1'b0, ok);
      if (ok) runFrame("mph65535", "569.50", 16'd56950, 100, 1'b0, 1'b1);

      // Reset after three bytes have been accepted
      applyStimulus(16'd10000, 1'b0, ok);
      budget = 0;
      while (!out_valid && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("midRst_firstValid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midRst_byte3", 64'(out_data), 64'h2E);
      rst       = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("midRst_outValid", 64'(out_valid), 64'd0);
      checkOutput("midRst_done",     64'(done),      64'd0);
      rst = 1'b0;
      #1;
      checkOutput("midRst_inReady", 64'(in_ready), 64'd1);
      doneSeen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("midRst_noDone", 64'(doneSeen), 64'd0);
      applyStimulus(16'd10000, 1'b0, ok);
      if (ok) runFrame("afterRst", "086.90", 16'd8690, 100, 1'b0, 1'b1);

      // Random back-pressure with busy-time input pulses
      applyStimulus(16'd10000, 1'b0, ok);
      if (ok) runFrame("stall30", "086.90", 16'd8690, 30, 1'b1, 1'b1);

      // Back-to-back with in_valid held high; second accept lands on the done cycle
      applyStimulus(16'd2000, 1'b1, ok);
      mph_x100_in = 16'd4000;
      if (ok) runFrame("b2bFirst", "017.38", 16'd1738, 100, 1'b0, 1'b1);
      in_valid = 1'b0;
      if (ok) runFrame("b2bSecond", "034.76", 16'd3476, 100, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/knots_ascii_encoder.md
# knots_ascii_encoder

Converts a binary speed in mph×100 to knots×100 and serializes it as a six-character ASCII field `DDD.DD` over a byte-stream valid/ready interface. It is the transmit-side counterpart of the ASCII-knots-to-mph path, used when the design emits NMEA-style speed fields toward the UART/sentence builder. Arithmetic is multi-cycle: one multiply, a sequential restoring divide by 1000, a double-dabble BCD conversion, then byte output.

## Interface
- K_NUM, 869, conversion numerator; knots = mph × K_NUM / 1000; legal range 1..1000.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  mph_x100_in is valid
- in_ready  out  1  block idle and accepting; `(state==IDLE) && !rst`
- mph_x100_in  in  16  speed in mph×100, unsigned
- out_valid  out  1  out_data holds a valid ASCII byte
- out_ready  in  1  downstream accepts byte
- out_data  out  8  ASCII byte
- out_last  out  1  high with the sixth byte (`0`-`9` fractional digit 2)
- knots_x100_out  out  16  binary knots×100 of most recent conversion
- done  out  1  one-cycle pulse after sixth byte handshake

## Operation
- States: IDLE, MUL, DIV, BCD, SEND.
- IDLE: in_valid&&in_ready captures mph_x100_in → MUL.
- MUL (1 cycle): prod[25:0] <= mph×K_NUM + 500 (rounding) → DIV.
- DIV (26 cycles): restoring division, one quotient bit per cycle MSB-first, divisor 1000, 11-bit partial remainder; quotient = floor(prod/1000), always < 65536; knots_x100_out updated with quotient[15:0] on last DIV edge → BCD.
- BCD (16 cycles): double-dabble on quotient[15:0] into 5 BCD digits d4..d0 (add 3 to any digit ≥5 before each shift) → SEND.
- SEND: bytes in order `d4`,`d3`,`d2`,`.`,`d1`,`d0` (digits + 8'h30, dot 8'h2E); leading zeros kept. Byte index advances only on out_valid&&out_ready. out_data/out_last stable while out_valid&&!out_ready. After byte 5 handshake: out_valid<=0, out_last<=0, done<=1 for one cycle, → IDLE.
- in_valid while not IDLE: ignored (in_ready low), no capture.
- rst at any time: state IDLE, partial transfer abandoned, no done pulse.

## Timing
- Reset values: out_valid 0, out_data 8'h00, out_last 0, done 0, knots_x100_out 0, in_ready 0 during rst, 1 first cycle after.
- Accept edge E0 → MUL; E1 product registered; E2..E27 divide bits; E28..E43 BCD shifts; E44 out_valid=1 with byte 0. Fixed latency: 44 edges accept-to-first-out_valid, independent of value.
- With out_ready held high: bytes on E44..E49 windows, last handshake at E50 edge, done high the cycle after E50, in_ready high same cycle as done.
- Minimum input spacing: 51 cycles.
- knots_x100_out valid from E28 onward, held until next conversion's E27.
- Widths: product 26 bits; max 65535×1000+500 = 65,535,500 fits.

## Test plan
- Reset mid-SEND after byte 2 accepted → out_valid 0 next cycle, in_ready 1, no done; subsequent conversion of 10000 outputs full `086.90`.
- mph 0 → knots_x100_out 0, bytes `0`,`0`,`0`,`.`,`0`,`0`, out_last on sixth, done pulse once.
- mph 1150 → knots_x100_out 999, `009.99`; mph 1 → 1, `000.01` (rounding up from 0.869).
- mph 65535 → knots_x100_out 56950, `569.50`; first out_valid exactly 44 cycles after accept edge.
- out_ready random 30% duty on mph 10000 → `086.90` in order, out_data stable across every stall, in_valid pulses during busy ignored.
- Back-to-back: in_valid held high with 2000 then 4000 → `017.38` then `034.76`, second accept on cycle done is high.
